module4_fine_cfo_cmul_pipe: RTL and testbench

// - Pipelined, parametrised signed complex multiplier for fine-CFO derotation in the synchronisation chain.
// - Successor to the single-cycle combinational real multiplier. Adds configurable depth, optional conjugation,

---
 rtl/module4_pkg.sv | 45 ++++
 rtl/module4_cmul_sat_round.sv | 29 ++
 rtl/module4_fine_cfo_cmul_pipe.sv | 228 ++++++++++++++++++++++
 tb/tb_module4_fine_cfo_cmul_pipe.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/module4_pkg.sv
// Shared types and arithmetic helpers for the module4 fine-CFO complex multiplier.
package module4_pkg;

  localparam int unsigned CPLX_W = 16;
  localparam int unsigned MAX_W  = 64;

  typedef struct packed {
    logic signed [CPLX_W-1:0] re;
    logic signed [CPLX_W-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic                    sat;
    logic signed [MAX_W-1:0] val;
  } sat_res_t;

  // Half-LSB constant added ahead of a right shift for round-half-up.
  function automatic logic signed [MAX_W-1:0] round_const(input int unsigned shift);
    logic signed [MAX_W-1:0] rc;
    rc = '0;
    if (shift != 0) rc = MAX_W'(1) <<< (shift - 1);
    return rc;
  endfunction

  // Clamp x to the signed out_w-bit range and flag when clamping occurred.
  function automatic sat_res_t sat_signed(input logic signed [MAX_W-1:0] x,
                                          input int unsigned out_w);
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    sat_res_t r;
    hi    = (MAX_W'(1) <<< (out_w - 1)) - MAX_W'(1);
    lo    = -hi - MAX_W'(1);
    r.sat = 1'b1;
    if (x > hi) begin
      r.val = hi;
    end else if (x < lo) begin
      r.val = lo;
    end else begin
      r.val = x;
      r.sat = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/module4_cmul_sat_round.sv
// Combinational round/truncate, arithmetic right shift and saturation of one
// full-precision product component.
module module4_cmul_sat_round
  import module4_pkg::*;
#(
  parameter int unsigned IN_W     = 34,
  parameter int unsigned OUT_W    = 16,
  parameter int unsigned SHIFT    = 15,
  parameter bit          ROUND_EN = 1'b1
) (
  input  logic signed [IN_W-1:0]  x,
  output logic signed [OUT_W-1:0] y_c,
  output logic                    sat_c
);

  logic signed [MAX_W-1:0] sum_c;
  logic signed [MAX_W-1:0] shr_c;
  sat_res_t                res_c;

  always_comb begin
    sum_c = MAX_W'(x);
    if (ROUND_EN) sum_c = sum_c + round_const(SHIFT);
    shr_c = sum_c >>> SHIFT;
    res_c = sat_signed(shr_c, OUT_W);
    y_c   = OUT_W'(res_c.val);
    sat_c = res_c.sat;
  end

endmodule

// File: rtl/module4_fine_cfo_cmul_pipe.sv
// Pipelined signed complex multiplier with optional conjugate, rounding, saturation
// and valid/ready flow control for fine-CFO derotation.
module module4_fine_cfo_cmul_pipe
  import module4_pkg::*;
#(
  parameter int unsigned A_W       = 16,
  parameter int unsigned B_W       = 16,
  parameter int unsigned OUT_W     = 16,
  parameter int unsigned SHIFT     = 15,
  parameter int unsigned NUM_STAGE = 3,
  parameter bit          ROUND_EN  = 1'b1
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [A_W-1:0]   s_a_re,
  input  logic signed [A_W-1:0]   s_a_im,
  input  logic signed [B_W-1:0]   s_b_re,
  input  logic signed [B_W-1:0]   s_b_im,
  input  logic                    s_conj,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [OUT_W-1:0] m_re,
  output logic signed [OUT_W-1:0] m_im,
  output logic                    m_sat,
  output logic [15:0]             sat_cnt,
  input  logic                    sat_clr
);

  localparam int unsigned BX_W    = B_W + 1;
  localparam int unsigned P_W     = A_W + BX_W;
  localparam int unsigned S_W     = P_W + 1;
  localparam int unsigned NUM_DLY = (NUM_STAGE > 3) ? NUM_STAGE - 3 : 0;

  typedef struct packed {
    logic                    vld;
    logic                    sat;
    logic signed [OUT_W-1:0] re;
    logic signed [OUT_W-1:0] im;
  } beat_t;

  logic en_c;
  assign en_c    = ~m_valid | m_ready;
  assign s_ready = en_c;

  // Stage 1: operand capture; b widened by one bit so negating -2^(B_W-1) is exact.
  logic                   v1_q, v1_d;
  logic signed [A_W-1:0]  ar_q, ar_d, ai_q, ai_d;
  logic signed [BX_W-1:0] br_q, br_d, bi_q, bi_d;

  always_comb begin
    v1_d = v1_q;
    ar_d = ar_q;
    ai_d = ai_q;
    br_d = br_q;
    bi_d = bi_q;
    if (en_c) begin
      v1_d = s_valid;
      if (s_valid) begin
        ar_d = s_a_re;
        ai_d = s_a_im;
        br_d = BX_W'(s_b_re);
        bi_d = s_conj ? -BX_W'(s_b_im) : BX_W'(s_b_im);
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      v1_q <= 1'b0;
      ar_q <= '0;
      ai_q <= '0;
      br_q <= '0;
      bi_q <= '0;
    end else begin
      v1_q <= v1_d;
      ar_q <= ar_d;
      ai_q <= ai_d;
      br_q <= br_d;
      bi_q <= bi_d;
    end
  end

  // Stage 2: partial products, registered unless the pipe is only two deep.
  logic signed [P_W-1:0] p_rr_c, p_ii_c, p_ri_c, p_ir_c;
  logic signed [P_W-1:0] p_rr_s, p_ii_s, p_ri_s, p_ir_s;
  logic                  v2_s;

  assign p_rr_c = P_W'(ar_q) * P_W'(br_q);
  assign p_ii_c = P_W'(ai_q) * P_W'(bi_q);
  assign p_ri_c = P_W'(ar_q) * P_W'(bi_q);
  assign p_ir_c = P_W'(ai_q) * P_W'(br_q);

  if (NUM_STAGE == 2) begin : g_merge
    assign p_rr_s = p_rr_c;
    assign p_ii_s = p_ii_c;
    assign p_ri_s = p_ri_c;
    assign p_ir_s = p_ir_c;
    assign v2_s   = v1_q;
  end else begin : g_prod
    logic                  v2_q, v2_d;
    logic signed [P_W-1:0] rr_q, rr_d, ii_q, ii_d, ri_q, ri_d, ir_q, ir_d;

    always_comb begin
      v2_d = v2_q;
      rr_d = rr_q;
      ii_d = ii_q;
      ri_d = ri_q;
      ir_d = ir_q;
      if (en_c) begin
        v2_d = v1_q;
        if (v1_q) begin
          rr_d = p_rr_c;
          ii_d = p_ii_c;
          ri_d = p_ri_c;
          ir_d = p_ir_c;
        end
      end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        v2_q <= 1'b0;
        rr_q <= '0;
        ii_q <= '0;
        ri_q <= '0;
        ir_q <= '0;
      end else begin
        v2_q <= v2_d;
        rr_q <= rr_d;
        ii_q <= ii_d;
        ri_q <= ri_d;
        ir_q <= ir_d;
      end
    end

    assign p_rr_s = rr_q;
    assign p_ii_s = ii_q;
    assign p_ri_s = ri_q;
    assign p_ir_s = ir_q;
    assign v2_s   = v2_q;
  end

  // Stage 3: complex combine, round, shift and saturate.
  logic signed [S_W-1:0]   re_sum_c, im_sum_c;
  logic signed [OUT_W-1:0] re_rs_c, im_rs_c;
  logic                    re_sat_c, im_sat_c;

  assign re_sum_c = S_W'(p_rr_s) - S_W'(p_ii_s);
  assign im_sum_c = S_W'(p_ri_s) + S_W'(p_ir_s);

  module4_cmul_sat_round #(
    .IN_W(S_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .ROUND_EN(ROUND_EN)
  ) u_re (
    .x(re_sum_c), .y_c(re_rs_c), .sat_c(re_sat_c)
  );

  module4_cmul_sat_round #(
    .IN_W(S_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .ROUND_EN(ROUND_EN)
  ) u_im (
    .x(im_sum_c), .y_c(im_rs_c), .sat_c(im_sat_c)
  );

  beat_t s3_q, s3_d;

  always_comb begin
    s3_d = s3_q;
    if (en_c) begin
      s3_d.vld = v2_s;
      if (v2_s) begin
        s3_d.sat = re_sat_c | im_sat_c;
        s3_d.re  = re_rs_c;
        s3_d.im  = im_rs_c;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) s3_q <= '0;
    else           s3_q <= s3_d;
  end

  // Stages 4..NUM_STAGE: pure delay of the finished beat.
  beat_t chain [NUM_DLY+1];
  assign chain[0] = s3_q;

  for (genvar i = 0; i < NUM_DLY; i++) begin : g_dly
    beat_t dly_q, dly_d;

    always_comb begin
      dly_d = dly_q;
      if (en_c) dly_d = chain[i];
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) dly_q <= '0;
      else           dly_q <= dly_d;
    end

    assign chain[i+1] = dly_q;
  end

  assign m_valid = chain[NUM_DLY].vld;
  assign m_sat   = chain[NUM_DLY].sat;
  assign m_re    = chain[NUM_DLY].re;
  assign m_im    = chain[NUM_DLY].im;

  // Saturated-beat counter; clear has priority and the count sticks at all-ones.
  logic [15:0] sat_cnt_q, sat_cnt_d;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (sat_clr) begin
      sat_cnt_d = '0;
    end else if (m_valid && m_ready && m_sat && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_d = sat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) sat_cnt_q <= '0;
    else           sat_cnt_q <= sat_cnt_d;
  end

  assign sat_cnt = sat_cnt_q;

endmodule

// File: tb/tb_module4_fine_cfo_cmul_pipe.sv
// Directed bench for module4_fine_cfo_cmul_pipe: four instances (depth 3 round,
// depth 3 truncate, depth 2, depth 6) share one stimulus stream.
module tb_module4_fine_cfo_cmul_pipe;
  import module4_pkg::*;

  localparam int ND = 4;

  typedef struct {
    cplx_t v;
    logic  sat;
    int    acc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic               s_valid, s_conj, m_ready, sat_clr;
  logic signed [15:0] s_a_re, s_a_im, s_b_re, s_b_im;

  logic               sr   [ND];
  logic               mv   [ND];
  logic signed [15:0] mre  [ND];
  logic signed [15:0] mim  [ND];
  logic               msat [ND];
  logic [15:0]        scnt [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    module4_fine_cfo_cmul_pipe #(
      .A_W(16), .B_W(16), .OUT_W(16), .SHIFT(15),
      .NUM_STAGE((g == 2) ? 2 : ((g == 3) ? 6 : 3)),
      .ROUND_EN(g != 1)
    ) u_dut (
      .ap_clk  (clk),
      .ap_rst_n(rst_n),
      .s_valid (s_valid),
      .s_ready (sr[g]),
      .s_a_re  (s_a_re),
      .s_a_im  (s_a_im),
      .s_b_re  (s_b_re),
      .s_b_im  (s_b_im),
      .s_conj  (s_conj),
      .m_valid (mv[g]),
      .m_ready (m_ready),
      .m_re    (mre[g]),
      .m_im    (mim[g]),
      .m_sat   (msat[g]),
      .sat_cnt (scnt[g]),
      .sat_clr (sat_clr)
    );
  end

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic lat_chk = 1'b0;
  logic acc0;
  exp_t pend1, pend0;
  exp_t sb [ND][$];
  logic               prev_stall [ND];
  logic signed [15:0] prev_re    [ND];
  logic signed [15:0] prev_im    [ND];
  logic               prev_sat   [ND];

  function automatic int ns_of(int d);
    return (d == 2) ? 2 : ((d == 3) ? 6 : 3);
  endfunction

  function automatic logic rnd_of(int d);
    return d != 1;
  endfunction

  task automatic chk(string tag, logic signed [31:0] obs, logic signed [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference model: exact integer complex product, optional half-up rounding, floor shift, clamp.
  function automatic exp_t model(int ar, int ai, int br, int bi, logic conj, logic rnd);
    exp_t   e;
    longint bie, re, im;
    bie = conj ? -longint'(bi) : longint'(bi);
    re  = longint'(ar) * longint'(br) - longint'(ai) * bie;
    im  = longint'(ar) * bie + longint'(ai) * longint'(br);
    if (rnd) begin
      re = re + 64'sd16384;
      im = im + 64'sd16384;
    end
    re    = re >>> 15;
    im    = im >>> 15;
    e.sat = 1'b0;
    if (re > 32767)       begin re = 32767;  e.sat = 1'b1; end
    else if (re < -32768) begin re = -32768; e.sat = 1'b1; end
    if (im > 32767)       begin im = 32767;  e.sat = 1'b1; end
    else if (im < -32768) begin im = -32768; e.sat = 1'b1; end
    e.v.re = 16'(re);
    e.v.im = 16'(im);
    e.acc  = 0;
    return e;
  endfunction

  // One clock: observe/score at the falling edge, then step past the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    acc0 = s_valid && sr[0];
    for (int d = 0; d < ND; d++) begin
      if (prev_stall[d]) begin
        chk($sformatf("d%0d stall m_valid", d), 32'(mv[d]), 1);
        chk($sformatf("d%0d stall m_re", d), mre[d], prev_re[d]);
        chk($sformatf("d%0d stall m_im", d), mim[d], prev_im[d]);
        chk($sformatf("d%0d stall m_sat", d), 32'(msat[d]), 32'(prev_sat[d]));
      end
      prev_stall[d] = mv[d] && !m_ready;
      prev_re[d]    = mre[d];
      prev_im[d]    = mim[d];
      prev_sat[d]   = msat[d];
      if (mv[d] && m_ready) begin
        chk($sformatf("d%0d beat expected", d), 32'(sb[d].size() > 0), 1);
        if (sb[d].size() > 0) begin
          e = sb[d].pop_front();
          chk($sformatf("d%0d m_re", d), mre[d], e.v.re);
          chk($sformatf("d%0d m_im", d), mim[d], e.v.im);
          chk($sformatf("d%0d m_sat", d), 32'(msat[d]), 32'(e.sat));
          if (lat_chk) chk($sformatf("d%0d latency", d), cyc - e.acc, ns_of(d));
        end
      end
      if (s_valid && sr[d]) begin
        e     = rnd_of(d) ? pend1 : pend0;
        e.acc = cyc;
        sb[d].push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k = 0;
    while (k < 30 && (sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()) != 0) begin
      tick();
      k++;
    end
    for (int d = 0; d < ND; d++) chk($sformatf("d%0d drained", d), sb[d].size(), 0);
  endtask

  task automatic set_ops(int ar, int ai, int br, int bi, logic conj);
    s_a_re = 16'(ar);
    s_a_im = 16'(ai);
    s_b_re = 16'(br);
    s_b_im = 16'(bi);
    s_conj = conj;
  endtask

  // Single directed beat with hand-computed results for rounding and truncating instances.
  task automatic send(int ar, int ai, int br, int bi, logic conj,
                      int r1re, int r1im, logic r1s, int r0re, int r0im, logic r0s);
    set_ops(ar, ai, br, bi, conj);
    pend1.v.re = 16'(r1re); pend1.v.im = 16'(r1im); pend1.sat = r1s;
    pend0.v.re = 16'(r0re); pend0.v.im = 16'(r0im); pend0.sat = r0s;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    drain();
  endtask

  task automatic new_beat();
    int   ar, ai, br, bi;
    logic cj;
    ar = int'($urandom_range(0, 65535)) - 32768;
    ai = int'($urandom_range(0, 65535)) - 32768;
    br = int'($urandom_range(0, 65535)) - 32768;
    bi = int'($urandom_range(0, 65535)) - 32768;
    cj = 1'($urandom_range(0, 1));
    set_ops(ar, ai, br, bi, cj);
    pend1 = model(ar, ai, br, bi, cj, 1'b1);
    pend0 = model(ar, ai, br, bi, cj, 1'b0);
  endtask

  initial begin
    int sent;
    int k;
    s_valid = 1'b0;
    m_ready = 1'b1;
    sat_clr = 1'b0;
    set_ops(0, 0, 0, 0, 1'b0);
    for (int d = 0; d < ND; d++) prev_stall[d] = 1'b0;

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("d%0d reset m_valid", d), 32'(mv[d]), 0);
      chk($sformatf("d%0d reset m_re", d), mre[d], 0);
      chk($sformatf("d%0d reset m_im", d), mim[d], 0);
      chk($sformatf("d%0d reset m_sat", d), 32'(msat[d]), 0);
      chk($sformatf("d%0d reset sat_cnt", d), 32'(scnt[d]), 0);
      chk($sformatf("d%0d reset s_ready", d), 32'(sr[d]), 1);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    lat_chk = 1'b1;
    send(16384, 0, 16384, 0, 1'b0, 8192, 0, 1'b0, 8192, 0, 1'b0);
    send(-32768, 0, -32768, 0, 1'b0, 32767, 0, 1'b1, 32767, 0, 1'b1);
    for (int d = 0; d < ND; d++) chk($sformatf("d%0d sat_cnt after sat", d), 32'(scnt[d]), 1);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    for (int d = 0; d < ND; d++) chk($sformatf("d%0d sat_cnt cleared", d), 32'(scnt[d]), 0);
    send(0, 16384, 0, 16384, 1'b0, -8192, 0, 1'b0, -8192, 0, 1'b0);
    send(0, 16384, 0, 16384, 1'b1, 8192, 0, 1'b0, 8192, 0, 1'b0);
    send(1, 0, 16384, 0, 1'b0, 1, 0, 1'b0, 0, 0, 1'b0);
    send(-1, 0, 16384, 0, 1'b0, 0, 0, 1'b0, -1, 0, 1'b0);
    send(32767, 0, 0, -32768, 1'b1, 0, 32767, 1'b0, 0, 32767, 1'b0);
    send(-32768, -32768, 32767, -32768, 1'b0, -32768, 1, 1'b1, -32768, 1, 1'b1);
    for (int d = 0; d < ND; d++) chk($sformatf("d%0d sat_cnt negative clamp", d), 32'(scnt[d]), 1);

    lat_chk = 1'b0;
    sent    = 0;
    k       = 0;
    new_beat();
    s_valid = 1'b1;
    while (sent < 64 && k < 300) begin
      m_ready = !(k >= 30 && k < 35);
      tick();
      k++;
      if (acc0) begin
        sent++;
        if (sent < 64) new_beat();
      end
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    chk("random beats accepted", sent, 64);
    drain();

    for (int i = 0; i < 3; i++) begin
      new_beat();
      s_valid = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("d%0d midreset m_valid", d), 32'(mv[d]), 0);
      chk($sformatf("d%0d midreset m_re", d), mre[d], 0);
      chk($sformatf("d%0d midreset sat_cnt", d), 32'(scnt[d]), 0);
      sb[d].delete();
      prev_stall[d] = 1'b0;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) tick();
    for (int d = 0; d < ND; d++) chk($sformatf("d%0d no stale beat", d), 32'(mv[d]), 0);
    lat_chk = 1'b1;
    send(16384, 0, 16384, 0, 1'b0, 8192, 0, 1'b0, 8192, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
